verifier_h_percopy_driver: RTL and testbench
============================================

VERIFIER_H_PERCOPY_DRIVER -- requirements
Module: verifier_h_percopy_driver

Interface
REQ-001 SHALL have parameter nCopies, default 16: number of circuit copies (>= 2).
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum wait, in cycles, for a prover acknowledge.
REQ-003 SHALL have localparam nCopyBits = $clog2(nCopies): number of challenge rounds.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-005 SHALL have port rstb, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1: start-run pulse.
REQ-007 SHALL have port chal_in, input, F_NBITS: challenge from the verifier randomness source.
REQ-008 SHALL have port chal_valid, input, 1: chal_in valid this cycle.
REQ-009 SHALL have port chal_req, output, 1: requests one challenge.
REQ-010 SHALL have port p_en, output, 1: single-cycle round start toward the prover.
REQ-011 SHALL have port p_restart, output, 1: first-round marker toward the prover.
REQ-012 SHALL have ports tau and m_tau_p1, output, F_NBITS each: challenge and (1 - tau) mod F_Q.
REQ-013 SHALL have port p_ready_pulse, input, 1: prover round acknowledge.
REQ-014 SHALL have port p_outputs_ready, input, 1: prover final outputs valid.
REQ-015 SHALL have ports z2 and m_z2_p1, output, [nCopyBits-1:0] x F_NBITS: recorded challenges.
REQ-016 SHALL have ports ready, ready_pulse and error, output, 1 each: idle/complete, completion pulse, protocol error.

Function
REQ-017 FSM states SHALL be IDLE, GET_CHAL, ISSUE, WAIT_ACK, DONE and ERROR.
REQ-018 IDLE: ready=1; en moves to GET_CHAL and clears the round counter and error.
REQ-019 GET_CHAL: chal_req=1; on chal_valid, latch tau=chal_in and m_tau_p1=(1-chal_in) mod F_Q, then go to ISSUE.
REQ-020 The m_tau_p1 computation SHALL equal ~tau + F_Q_P2_MI, reduced mod F_Q.
REQ-021 chal_in >= F_Q SHALL be reduced mod F_Q before latching.
REQ-022 ISSUE: assert p_en for exactly 1 cycle and p_restart=1 iff round==0; store tau/m_tau_p1 into z2[round]/m_z2_p1[round]; go to WAIT_ACK.
REQ-023 tau and m_tau_p1 SHALL hold stable from ISSUE until the next GET_CHAL latch.
REQ-024 WAIT_ACK, on p_ready_pulse: increment round; if round < nCopyBits go to GET_CHAL, else go to DONE.
REQ-025 DONE: require p_outputs_ready=1, else go to ERROR; pulse ready_pulse for 1 cycle; go to IDLE.
REQ-026 p_outputs_ready=1 observed in WAIT_ACK before the final round SHALL go to ERROR.
REQ-027 p_ready_pulse outside WAIT_ACK SHALL be ignored, except in GET_CHAL, where it SHALL go to ERROR.
REQ-028 ERROR: error=1 and ready=1 (sticky); en restarts as from IDLE.
REQ-029 en outside IDLE/ERROR SHALL be ignored.
REQ-030 chal_valid outside GET_CHAL SHALL be ignored.
REQ-031 Minimum latency from en to ready_pulse SHALL be 4*nCopyBits+1 cycles, given a zero-wait challenge source and an immediate acknowledge.

Reset
REQ-032 On rstb low: state=IDLE; ready=1; all other outputs, z2, m_z2_p1 and counters = 0.
REQ-033 Reset mid-run SHALL abort without emitting p_en.

Configuration
REQ-034 With VERIFIER_H_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT_ACK; reaching TIMEOUT cycles with no p_ready_pulse goes to ERROR.
REQ-035 Without VERIFIER_H_TIMEOUT_EN, the counter logic SHALL be absent and WAIT_ACK SHALL wait indefinitely.

Structure
REQ-036 F_NBITS, F_Q and F_Q_P2_MI SHALL come from field_arith_defs.
REQ-037 The FSM state enum SHALL live in shared package verifier_pkg.
REQ-038 The combinational sub-module field_one_minus SHALL compute (1 - x) mod F_Q, including the input reduction.

Verification
REQ-039 chal_in = 0, 1, F_Q-1 -> m_tau_p1 = 1, 0, 2 respectively.
REQ-040 nCopies=16, random challenges, prover model acks 3 cycles after p_en -> exactly 4 p_en pulses; p_restart only on the first; z2[i] equals challenge i; one ready_pulse.
REQ-041 p_outputs_ready low in DONE -> error=1 and no ready_pulse.
REQ-042 p_ready_pulse injected in GET_CHAL -> ERROR; a subsequent en completes a clean run with error cleared.
REQ-043 rstb low in WAIT_ACK of round 2 -> all outputs 0, ready=1 next edge, and no p_en afterward.
REQ-044 With VERIFIER_H_TIMEOUT_EN and TIMEOUT=8, no acknowledge -> error asserted exactly 8 cycles after WAIT_ACK entry.

Source files
------------

// File: rtl/field_arith_defs.sv
// field_arith_defs: constants of the Mersenne prime field
// p = 2^61 - 1 used by the verifier datapath.
package field_arith_defs;

  localparam int F_NBITS = 61;

  localparam logic [F_NBITS-1:0] F_Q =
    {F_NBITS{1'b1}};

  // F_Q + 2 - 2^F_NBITS, so ~x + F_Q_P2_MI == 1 - x mod F_Q
  localparam logic [F_NBITS-1:0] F_Q_P2_MI =
    {{(F_NBITS-1){1'b0}}, 1'b1};

endpackage

// File: rtl/verifier_pkg.sv
// verifier_pkg: shared types of the verifier control path,
// including the per-copy driver FSM state.
package verifier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CHAL,
    ISSUE,
    WAIT_ACK,
    DONE,
    ERROR
  } vstate_e;

endpackage

// File: rtl/field_one_minus.sv
// field_one_minus: reduces x into [0, F_Q) and returns
// (1 - x) mod F_Q as ~x + F_Q_P2_MI with one final subtract.
module field_one_minus
  import field_arith_defs::*;
(
  input  logic [F_NBITS-1:0] x,
  output logic [F_NBITS-1:0] x_red,
  output logic [F_NBITS-1:0] y
);

  logic [F_NBITS:0] sum;

  // reduce, complement-add, then fold the sum back below F_Q
  always_comb begin
    x_red = (x >= F_Q) ? x - F_Q : x;
    sum   = {1'b0, ~x_red} + {1'b0, F_Q_P2_MI};
    if (sum >= {1'b0, F_Q}) begin
      y = F_NBITS'(sum - {1'b0, F_Q});
    end else begin
      y = sum[F_NBITS-1:0];
    end
  end

endmodule

// File: rtl/verifier_h_percopy_driver.sv
// verifier_h_percopy_driver: runs nCopyBits challenge rounds
// with the prover. Optional VERIFIER_H_TIMEOUT_EN: ack timeout.
module verifier_h_percopy_driver
  import verifier_pkg::*;
  import field_arith_defs::*;
#(
  parameter int nCopies = 16,
  parameter int TIMEOUT = 1024,
  localparam int nCopyBits = $clog2(nCopies)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic [F_NBITS-1:0]   chal_in,
  input  logic                 chal_valid,
  output logic                 chal_req,
  output logic                 p_en,
  output logic                 p_restart,
  output logic [F_NBITS-1:0]   tau,
  output logic [F_NBITS-1:0]   m_tau_p1,
  input  logic                 p_ready_pulse,
  input  logic                 p_outputs_ready,
  output logic [nCopyBits-1:0][F_NBITS-1:0] z2,
  output logic [nCopyBits-1:0][F_NBITS-1:0] m_z2_p1,
  output logic                 ready,
  output logic                 ready_pulse,
  output logic                 error
);

  localparam int RW = $clog2(nCopyBits + 1);
  localparam logic [RW-1:0] LAST = RW'(nCopyBits - 1);

  vstate_e            state_q;
  vstate_e            state_d;
  logic [RW-1:0]      round_q;
  logic [F_NBITS-1:0] chal_red;
  logic [F_NBITS-1:0] chal_omx;
  logic               ack_timeout;

  field_one_minus u_one_minus (
    .x     (chal_in),
    .x_red (chal_red),
    .y     (chal_omx)
  );

`ifdef VERIFIER_H_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt_q;

  // cycles spent in WAIT_ACK without an acknowledge
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT_ACK) begin
      wait_cnt_q <= wait_cnt_q + TW'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign ack_timeout = (wait_cnt_q == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign ack_timeout    = 1'b0;
`endif

  assign ready       = (state_q == IDLE) ||
                       (state_q == ERROR);
  assign chal_req    = (state_q == GET_CHAL);
  assign p_en        = (state_q == ISSUE);
  assign p_restart   = p_en && (round_q == '0);
  assign ready_pulse = (state_q == DONE) &&
                       p_outputs_ready;
  assign error       = (state_q == ERROR);

  // round sequencing and protocol-violation detection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = GET_CHAL;
      end
      GET_CHAL: begin
        if (p_ready_pulse) state_d = ERROR;
        else if (chal_valid) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (p_outputs_ready && round_q != LAST)
          state_d = ERROR;
        else if (p_ready_pulse)
          state_d = (round_q == LAST) ? DONE : GET_CHAL;
        else if (ack_timeout)
          state_d = ERROR;
      end
      DONE: begin
        state_d = p_outputs_ready ? IDLE : ERROR;
      end
      ERROR: begin
        if (en) state_d = GET_CHAL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, round counter, challenge and record registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      round_q  <= '0;
      tau      <= '0;
      m_tau_p1 <= '0;
      z2       <= '0;
      m_z2_p1  <= '0;
    end else begin
      state_q <= state_d;
      if (en && (state_q == IDLE || state_q == ERROR)) begin
        round_q <= '0;
      end
      if (state_q == GET_CHAL && state_d == ISSUE) begin
        tau      <= chal_red;
        m_tau_p1 <= chal_omx;
      end
      if (state_q == ISSUE) begin
        for (int i = 0; i < nCopyBits; i++) begin
          if (round_q == RW'(i)) begin
            z2[i]      <= tau;
            m_z2_p1[i] <= m_tau_p1;
          end
        end
      end
      if (state_q == WAIT_ACK &&
          (state_d == GET_CHAL || state_d == DONE)) begin
        round_q <= round_q + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_verifier_h_percopy_driver.sv
// tb_verifier_h_percopy_driver: table and scoreboard checks of
// the per-copy driver; VERIFIER_H_TIMEOUT_EN adds the timeout case.
module tb_verifier_h_percopy_driver;

  localparam int FN = 61;
  localparam int NR = 4;
  localparam logic [FN-1:0] TQ = 61'h1FFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [FN-1:0] chal;
    logic [FN-1:0] tau;
    logic [FN-1:0] mtp;
  } vec_t;

  logic clk;
  logic rstb;
  logic en;
  logic [FN-1:0] chal_in;
  logic chal_valid;
  logic chal_req;
  logic p_en;
  logic p_restart;
  logic [FN-1:0] tau;
  logic [FN-1:0] m_tau_p1;
  logic p_ready_pulse;
  logic p_outputs_ready;
  logic [NR-1:0][FN-1:0] z2;
  logic [NR-1:0][FN-1:0] m_z2_p1;
  logic ready;
  logic ready_pulse;
  logic error;

  int n_checks = 0;
  int n_err = 0;

  int r_pen, r_rp, r_lat, r_err_c, r_pen_c;
  bit r_err;

  vec_t src_q[$];
  vec_t exp_q[$];
  vec_t log_q[$];
  vec_t tbl[8];

  verifier_h_percopy_driver #(
    .nCopies (16),
    .TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rstb            (rstb),
    .en              (en),
    .chal_in         (chal_in),
    .chal_valid      (chal_valid),
    .chal_req        (chal_req),
    .p_en            (p_en),
    .p_restart       (p_restart),
    .tau             (tau),
    .m_tau_p1        (m_tau_p1),
    .p_ready_pulse   (p_ready_pulse),
    .p_outputs_ready (p_outputs_ready),
    .z2              (z2),
    .m_z2_p1         (m_z2_p1),
    .ready           (ready),
    .ready_pulse     (ready_pulse),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [FN-1:0] c,
                              input logic [FN-1:0] t,
                              input logic [FN-1:0] m);
    vec_t v;
    v.chal = c;
    v.tau  = t;
    v.mtp  = m;
    return v;
  endfunction

  function automatic vec_t model(input logic [FN-1:0] c);
    logic [FN-1:0] r;
    r = (c >= TQ) ? c - TQ : c;
    if (r == '0) return mk(c, r, 61'd1);
    return mk(c, r, TQ - r + 61'd1);
  endfunction

  // one run from en; ack_d cycles from p_en to ack
  task automatic run(input int ack_d,
                     input bit outs_ok,
                     input bit inject,
                     input int rst_pen);
    int ack_at, rst_c, n_ack;
    bit req_prev, inj_done, done;
    logic [63:0] w;
    vec_t v, e;
    r_pen = 0; r_rp = 0; r_lat = -1;
    r_err = 0; r_err_c = -1; r_pen_c = -1;
    ack_at = -1; rst_c = -1; n_ack = 0;
    req_prev = 0; inj_done = 0; done = 0;
    exp_q.delete();
    log_q.delete();
    en = 1'b1;
    for (int c = 1; c <= 400 && !done; c++) begin
      cycle();
      en = 1'b0;
      if (c == rst_c) begin
        rstb = 1'b0;
        #1;
        done = 1;
      end else begin
        if (p_en) begin
          r_pen++;
          r_pen_c = c;
          chk("p_restart", 64'(p_restart),
              64'(r_pen == 1));
          chk("sb nonempty", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tau", 64'(tau), 64'(e.tau));
            chk("m_tau_p1", 64'(m_tau_p1), 64'(e.mtp));
          end
          ack_at = c + ack_d;
          if (r_pen == rst_pen) begin
            rst_c  = c + 1;
            ack_at = -1;
          end
        end
        if (ready_pulse) begin
          r_rp++;
          r_lat = c;
        end
        if (error && !r_err) begin
          r_err   = 1;
          r_err_c = c;
        end
        if (ready) begin
          done = 1;
        end else begin
          p_ready_pulse = (c == ack_at);
          if (c == ack_at) begin
            n_ack++;
            if (n_ack == NR && outs_ok)
              p_outputs_ready = 1'b1;
          end
          if (inject && chal_req && !req_prev &&
              r_pen == 1 && !inj_done) begin
            p_ready_pulse = 1'b1;
            inj_done = 1;
          end
          if (chal_valid) begin
            chal_valid = 1'b0;
          end else if (req_prev && chal_req) begin
            if (src_q.size() != 0) begin
              v = src_q.pop_front();
            end else begin
              w = {$urandom(), $urandom()};
              v = model(w[FN-1:0]);
            end
            chal_in    = v.chal;
            chal_valid = 1'b1;
            exp_q.push_back(v);
            log_q.push_back(v);
          end
          req_prev = chal_req;
        end
      end
    end
    chk("run bounded", 64'(done), 64'(1));
    en = 1'b0;
    chal_valid = 1'b0;
    p_ready_pulse = 1'b0;
    p_outputs_ready = 1'b0;
  endtask

  task automatic chk_records();
    for (int i = 0; i < NR; i++) begin
      if (i < log_q.size()) begin
        chk("z2", 64'(z2[i]), 64'(log_q[i].tau));
        chk("m_z2_p1", 64'(m_z2_p1[i]),
            64'(log_q[i].mtp));
      end else begin
        chk("challenge count", 64'(log_q.size()),
            64'(NR));
      end
    end
  endtask

  initial begin
    int n;
    rstb = 1'b0;
    en = 1'b0;
    chal_in = '0;
    chal_valid = 1'b0;
    p_ready_pulse = 1'b0;
    p_outputs_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("rst ready", 64'(ready), 64'(1));
    chk("rst chal_req", 64'(chal_req), 64'(0));
    chk("rst p_en", 64'(p_en), 64'(0));
    chk("rst p_restart", 64'(p_restart), 64'(0));
    chk("rst ready_pulse", 64'(ready_pulse), 64'(0));
    chk("rst error", 64'(error), 64'(0));
    chk("rst tau", 64'(tau), 64'(0));
    chk("rst m_tau_p1", 64'(m_tau_p1), 64'(0));
    chk("rst z2", 64'(z2 == '0), 64'(1));
    chk("rst m_z2_p1", 64'(m_z2_p1 == '0), 64'(1));
    rstb = 1'b1;
    cycle();
    cycle();

    tbl[0] = mk(61'd0, 61'd0, 61'd1);
    tbl[1] = mk(61'd1, 61'd1, 61'd0);
    tbl[2] = mk(TQ - 61'd1, TQ - 61'd1, 61'd2);
    tbl[3] = mk(TQ, 61'd0, 61'd1);
    tbl[4] = mk(61'd2, 61'd2, TQ - 61'd1);
    tbl[5] = mk(TQ - 61'd2, TQ - 61'd2, 61'd3);
    tbl[6] = mk(61'd1000, 61'd1000, TQ - 61'd999);
    tbl[7] = mk(61'h1 << 60, 61'h1 << 60, 61'h1 << 60);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NR; k++)
        src_q.push_back(tbl[r * NR + k]);
      run(1, 1, 0, 0);
      chk("tbl p_en count", 64'(r_pen), 64'(NR));
      chk("tbl ready_pulse", 64'(r_rp), 64'(1));
      chk("tbl error", 64'(r_err), 64'(0));
      chk("tbl latency", 64'(r_lat), 64'(4 * NR + 1));
      chk_records();
      cycle();
    end

    run(3, 1, 0, 0);
    chk("rand p_en count", 64'(r_pen), 64'(NR));
    chk("rand ready_pulse", 64'(r_rp), 64'(1));
    chk("rand error", 64'(r_err), 64'(0));
    chk("rand latency", 64'(r_lat), 64'(25));
    chk_records();
    cycle();

    run(1, 0, 0, 0);
    chk("noout error", 64'(r_err), 64'(1));
    chk("noout ready_pulse", 64'(r_rp), 64'(0));
    chk("noout err cycle", 64'(r_err_c), 64'(18));
    chk("noout sticky", 64'({error, ready}), 64'(3));
    cycle();
    chk("noout hold", 64'({error, ready}), 64'(3));

    run(1, 1, 1, 0);
    chk("inject error", 64'(r_err), 64'(1));
    chk("inject p_en", 64'(r_pen), 64'(1));
    chk("inject err cycle", 64'(r_err_c), 64'(6));
    cycle();
    run(1, 1, 0, 0);
    chk("recover error", 64'(r_err), 64'(0));
    chk("recover ready_pulse", 64'(r_rp), 64'(1));
    chk("recover p_en", 64'(r_pen), 64'(NR));
    chk("recover idle", 64'({error, ready}), 64'(1));
    chk_records();
    cycle();

    run(1, 1, 0, 3);
    chk("rst mid p_en", 64'(r_pen), 64'(3));
    chk("rst mid ready", 64'(ready), 64'(1));
    chk("rst mid outs", 64'({chal_req, p_en, p_restart,
        ready_pulse, error}), 64'(0));
    chk("rst mid tau", 64'({tau, m_tau_p1} == '0), 64'(1));
    chk("rst mid z2", 64'(z2 == '0), 64'(1));
    chk("rst mid m_z2", 64'(m_z2_p1 == '0), 64'(1));
    cycle();
    chk("rst edge ready", 64'(ready), 64'(1));
    rstb = 1'b1;
    chal_valid = 1'b1;
    p_ready_pulse = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (p_en) n++;
    end
    chal_valid = 1'b0;
    p_ready_pulse = 1'b0;
    chk("post rst p_en", 64'(n), 64'(0));
    chk("idle ignores", 64'({error, ready}), 64'(1));
    cycle();

`ifdef VERIFIER_H_TIMEOUT_EN
    run(1000, 1, 0, 0);
    chk("timeout error", 64'(r_err), 64'(1));
    chk("timeout p_en", 64'(r_pen), 64'(1));
    chk("timeout cycles",
        64'(r_err_c - (r_pen_c + 1)), 64'(8));
`else
    run(30, 1, 0, 0);
    chk("long wait error", 64'(r_err), 64'(0));
    chk("long wait done", 64'(r_rp), 64'(1));
    chk("long wait latency", 64'(r_lat), 64'(133));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
